// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter: 32-bit words through a FIFO, sent LSB byte first, with a sent-byte address counter
module uart_tx #(
    parameter int BPS_CNT    = 10416,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataIn,
    input  logic        DataValid,
    output logic        DataReady,
    output logic        tx,
    output logic        Busy,
    output logic        Sent,
    output logic [31:0] Address
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BPS_CNT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state;
    state_t        state_nx;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shreg;
    logic          bit_end;
    logic          tx_nx;
    logic          word_done;
    logic          done_d;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign DataReady = !full;
    // No pass-through: a full FIFO refuses a word even on the cycle it pops.
    assign push      = DataValid && !full;
    assign bit_end   = (baud_cnt == CW'(BPS_CNT - 1));
    assign Busy      = !empty || (state != S_IDLE);

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic, line level for the next cycle, FIFO pop and word completion.
    always_comb begin
        state_nx  = state;
        tx_nx     = 1'b1;
        pop       = 1'b0;
        word_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                tx_nx = 1'b0;
                if (bit_end) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                tx_nx = shreg[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx == 2'd3) begin
                        word_done = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx  = S_START;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: baud/bit/byte counters, shift register, registered line,
    // and completion pulse delayed to line the pulse up with the end of the registered stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            done_d   <= 1'b0;
            Sent     <= 1'b0;
            Address  <= '0;
        end else begin
            tx     <= tx_nx;
            done_d <= word_done;
            Sent   <= done_d;
            if (done_d) begin
                Address <= Address + 32'd4;
            end
            if ((state == S_IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
            if (pop) begin
                shreg    <= mem[rd_ptr];
                byte_idx <= '0;
                bit_idx  <= '0;
            end
            if ((state == S_DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == S_STOP) && bit_end && (byte_idx != 2'd3)) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= {8'h00, shreg[31:8]};
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: framing, timing, back-to-back, full FIFO, reset, address wrap
module tb_uart_tx;
    localparam int BPS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] DataIn;
    logic        DataValid;
    logic        DataReady;
    logic        tx;
    logic        Busy;
    logic        Sent;
    logic [31:0] Address;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sent_cnt = 0;
    int sent_cyc = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.BPS_CNT(BPS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .DataIn(DataIn), .DataValid(DataValid),
        .DataReady(DataReady), .tx(tx), .Busy(Busy), .Sent(Sent), .Address(Address)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Sent === 1'b1) begin
            sent_cnt <= sent_cnt + 1;
            sent_cyc <= cyc;
        end
    end

    task automatic push_word(input logic [31:0] w, output int acc_cyc);
        int n = 0;
        DataIn = w;
        DataValid = 1'b1;
        @(negedge clk);
        while (DataReady !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (DataReady !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout word=%h ready=%b required=1", w, DataReady);
            DataValid = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        DataValid = 1'b0;
        DataIn = $urandom();
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic ok, output int t_fall, output int gap);
        int n = 0;
        logic [9:0] bits;
        logic first;
        ok = 1'b1;
        while (tx !== 1'b0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        gap = n;
        if (tx !== 1'b0) begin
            ok = 1'b0;
            b = 8'hxx;
            t_fall = -1;
            return;
        end
        t_fall = cyc;
        for (int j = 0; j < 10; j++) begin
            first = tx;
            for (int s = 0; s < BPS; s++) begin
                if (tx !== first) ok = 1'b0;
                @(posedge clk);
                #1;
            end
            bits[j] = first;
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
        b = bits[8:1];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        DataValid = 1'b0;
        DataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b required=1", tx); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", Busy); end
        checks++; if (Address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h required=0", Address); end
        checks++; if (DataReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", DataReady); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int acc, tf, tf0, gap, s0;
        logic [7:0] b, e;
        logic ok;
        s0 = sent_cnt;
        push_word(32'h44332211, acc);
        tf0 = -1;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, ok, tf, gap);
            if (i == 0) tf0 = tf;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || b !== e) begin errors++; $display("FAIL single_byte%0d got=%h frame_ok=%b required=%h", i, b, ok, e); end
        end
        checks++; if (tf0 - acc != 2) begin errors++; $display("FAIL single_latency got=%0d required=2", tf0 - acc); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL single_sent_count got=%0d required=1", sent_cnt - s0); end
        checks++; if (sent_cyc - tf0 != 40 * BPS) begin errors++; $display("FAIL single_sent_time got=%0d required=%0d", sent_cyc - tf0, 40 * BPS); end
        checks++; if (Address !== 32'h4) begin errors++; $display("FAIL single_addr got=%h required=4", Address); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b required=0", Busy); end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [31:0] a0;
        a0 = Address;
        fork
            begin
                push_word(32'hAAAAAAAA, acc);
                push_word(32'hBBBBBBBB, acc);
                push_word(32'hCCCCCCCC, acc);
            end
            begin
                int tf, gap;
                logic [7:0] b, e;
                logic ok;
                for (int i = 0; i < 12; i++) begin
                    recv_byte(b, ok, tf, gap);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    checks++;
                    if (!ok || b !== e) begin errors++; $display("FAIL b2b_byte%0d got=%h frame_ok=%b required=%h", i, b, ok, e); end
                    if (i > 0) begin
                        checks++;
                        if (gap != ((i % 4 == 0) ? 1 : 0)) begin
                            errors++;
                            $display("FAIL b2b_gap%0d got=%0d required=%0d", i, gap, (i % 4 == 0) ? 1 : 0);
                        end
                    end
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Address - a0 !== 32'hC) begin errors++; $display("FAIL b2b_addr got=%h required=%h", Address, a0 + 32'hC); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b required=0", Busy); end
    endtask

    task automatic test_full_fifo();
        logic [31:0] a0;
        a0 = Address;
        fork
            begin
                int acc, s;
                for (int i = 0; i < 5; i++) push_word(32'h10101010 * (i + 1) + 32'h00C0FFEE, acc);
                checks++; if (DataReady !== 1'b0) begin errors++; $display("FAIL full_ready got=%b required=0", DataReady); end
                s = sent_cnt;
                push_word(32'h600DF00D, acc);
                checks++;
                if (sent_cnt - s < 1) begin errors++; $display("FAIL full_early_accept sent_before_accept=%0d required>=1", sent_cnt - s); end
            end
            begin
                int tf, gap;
                logic [7:0] b, e;
                logic ok;
                for (int i = 0; i < 24; i++) begin
                    recv_byte(b, ok, tf, gap);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    checks++;
                    if (!ok || b !== e) begin errors++; $display("FAIL full_byte%0d got=%h frame_ok=%b required=%h", i, b, ok, e); end
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Address - a0 !== 32'd24) begin errors++; $display("FAIL full_addr got=%h required=%h", Address, a0 + 32'd24); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL full_busy got=%b required=0", Busy); end
    endtask

    task automatic test_bit_pattern();
        int acc;
        fork
            begin
                push_word(32'h000000FF, acc);
                push_word(32'h00000000, acc);
            end
            begin
                int tf, gap;
                logic [7:0] b, e;
                logic ok;
                for (int i = 0; i < 8; i++) begin
                    recv_byte(b, ok, tf, gap);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    checks++;
                    if (!ok || b !== e) begin errors++; $display("FAIL pattern_byte%0d got=%h frame_ok=%b required=%h", i, b, ok, e); end
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        int acc, s0, lows;
        s0 = sent_cnt;
        push_word(32'hDEADBEEF, acc);
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got=%b required=1", tx); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b required=0", Busy); end
        checks++; if (Address !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got=%h required=0", Address); end
        checks++; if (DataReady !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b required=1", DataReady); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL rst_mid_line_active got=%0d required=0", lows); end
        checks++; if (sent_cnt != s0) begin errors++; $display("FAIL rst_mid_sent got=%0d required=0", sent_cnt - s0); end
    endtask

    task automatic test_wrap();
        int acc, s0;
        force dut.Address = 32'hFFFFFFFC;
        #1;
        release dut.Address;
        @(posedge clk);
        #1;
        checks++; if (Address !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_preset got=%h required=fffffffc", Address); end
        s0 = sent_cnt;
        fork
            push_word(32'h87654321, acc);
            begin
                int tf, gap;
                logic [7:0] b, e;
                logic ok;
                for (int i = 0; i < 4; i++) begin
                    recv_byte(b, ok, tf, gap);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    checks++;
                    if (!ok || b !== e) begin errors++; $display("FAIL wrap_byte%0d got=%h frame_ok=%b required=%h", i, b, ok, e); end
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Address !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h required=0", Address); end
        checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL wrap_sent got=%0d required=1", sent_cnt - s0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_bit_pattern();
        test_reset_midframe();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that returns data from the board to the host PC over the same 8N1 serial link the loader's `Uart` receiver uses, in the opposite direction. It accepts 32-bit words through a valid/ready handshake, buffers them in a small FIFO and serialises each word as four bytes, least-significant byte first. It keeps a byte-address counter that mirrors the receiver's `Address`, so host-side tooling can use one framing and addressing model for both directions. It sits next to `Uart` in the top level and drives the board's TX pin.

## Interface
- `BPS_CNT`, default 10416: clock cycles per UART bit (9600 baud at 100 MHz); legal minimum 2.
- `FIFO_DEPTH`, default 4: word entries in the input FIFO; power of two, minimum 2.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `DataIn`  in  32  word to transmit; sampled when `DataValid & DataReady`.
- `DataValid`  in  1  producer has a word on `DataIn`.
- `DataReady`  out  1  FIFO not full; a word is accepted on any rising edge where `DataValid & DataReady` is 1.
- `tx`  out  1  serial line, registered; idles high.
- `Busy`  out  1  high while FIFO non-empty or a word is being shifted.
- `Sent`  out  1  one-cycle pulse when the stop bit of a word's 4th byte completes.
- `Address`  out  32  byte count of fully sent words (+4 per word).

## Operation
- Frame per byte is 8N1:
  - one start bit (0), then 8 data bits LSB first, then one stop bit (1).
  - Each bit is held exactly `BPS_CNT` cycles, counted by a baud counter running from 0 to `BPS_CNT-1`.
- Byte order within a word: `DataIn[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head word into the shift register, clear the byte index and go to START.
  - START: `tx`=0 for `BPS_CNT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = current bit. After `BPS_CNT` cycles, advance the bit index; after bit 7, go to STOP.
  - STOP: `tx`=1 for `BPS_CNT` cycles. Then:
    - if byte index < 3: increment it, shift the next byte in, go to START with no idle gap;
    - else: pulse `Sent`, add 4 to `Address`, go to IDLE.
- FIFO:
  - Write on handshake; read only from IDLE.
  - `DataReady` = !full, combinational from the registered full flag. There is no pass-through, so a word offered while full is not accepted, even on the cycle the FIFO pops.
  - Simultaneous push and pop on a non-full FIFO are both performed; occupancy is unchanged.
- `Address` wraps from 0xFFFFFFFC to 0x00000000 with no flag.
- `DataIn` is ignored when the handshake does not fire.
- Reset (asynchronous, at any time, including mid-bit):
  - `tx`=1, FIFO emptied, FSM to IDLE, counters cleared.
  - `Busy`=0, `Sent`=0, `Address`=0; `DataReady`=1 once the FIFO is empty.
  - A partially sent byte is abandoned; no completion pulse.

## Timing
- Accept latency: word accepted at edge k with FIFO empty and FSM in IDLE.
  - The FIFO entry is visible at k; IDLE pops at edge k+1.
  - `tx` falls at edge k+2.
- Word duration: 40×`BPS_CNT` cycles from `tx` falling for the first start bit to the end of the 4th stop bit.
- `Sent` is high for the single cycle after the last stop bit; `Address` updates on the same edge.
- Inter-word gap: exactly 1 extra idle cycle (the IDLE state) on top of the stop bit when the FIFO is already non-empty.
- `Busy` rises the cycle after the first accept. It falls on the edge entering IDLE with the FIFO empty.

## Test plan
- **Reset:** assert `reset` mid-frame → `tx`=1, `Busy`=0, `Address`=0, `DataReady`=1 immediately; no `Sent` pulse.
- **Single word:** with `BPS_CNT`=16, send 0x44332211 → line decodes bytes 0x11, 0x22, 0x33, 0x44.
  - Each bit lasts 16 cycles; `tx` falls 2 cycles after accept.
  - `Sent` pulses once, 640 cycles after the first falling edge; `Address`=0x4.
- **Back-to-back:** push 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC in consecutive cycles → 12 bytes in order, 1 idle cycle between words, `Address`=0xC, `Busy` low at the end.
- **Full FIFO:** push 5 words while the first is still shifting → `DataReady`=0 after the 5th word occupies the FIFO (4 buffered + 1 in the shifter).
  - A 6th word held valid is not accepted until one FIFO slot frees.
  - All 5 words are transmitted intact.
- **Bit pattern:** send 0x000000FF and 0x00000000 → exact frames 0-11111111-1 and 0-00000000-1 per byte; stop bits are always 1.
- **Wrap:** force `Address` to 0xFFFFFFFC, send 1 word → `Address`=0x0.
